// File: rtl/icache_pkg.sv
// Shared geometry constants and FSM state encoding for the instruction cache.
package icache_pkg;

  localparam int IBLOCK_SIZE_BITS     = 128;
  localparam int IMEM_BLOCK_ADDR_SIZE = 28;
  localparam int ICACHE_NUM_LINES     = 16;
  localparam int ICACHE_BLOCK_WORDS   = IBLOCK_SIZE_BITS / 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_mem_if.sv
// Block-refill bus between the instruction cache (master) and instruction memory (slave).
interface icache_mem_if
  import icache_pkg::*;
#(
  parameter int BLOCK_BITS = IBLOCK_SIZE_BITS,
  parameter int BADDR_BITS = IMEM_BLOCK_ADDR_SIZE
) ();

  logic                  mem_ren;
  logic [BADDR_BITS-1:0] mem_block_address;
  logic                  mem_ready;
  logic [BLOCK_BITS-1:0] mem_dout;

  modport master (
    output mem_ren,
    output mem_block_address,
    input  mem_ready,
    input  mem_dout
  );

  modport slave (
    input  mem_ren,
    input  mem_block_address,
    output mem_ready,
    output mem_dout
  );

endinterface

// File: rtl/icache_line_array.sv
// Direct-mapped tag/valid/data storage: one write port, one combinational read port,
// synchronous clear-all and asynchronous reset of the valid bits only.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int BLOCK_BITS = IBLOCK_SIZE_BITS,
  parameter int IDX_W      = 4,
  parameter int TAG_W      = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_all,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [TAG_W-1:0]      wtag,
  input  logic [BLOCK_BITS-1:0] wdata,
  input  logic                  wvalid,
  input  logic [IDX_W-1:0]      ridx,
  output logic [TAG_W-1:0]      rtag,
  output logic                  rvalid,
  output logic [BLOCK_BITS-1:0] rdata
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= wvalid;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-cycle hits and single-block refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_LINES   = ICACHE_NUM_LINES,
  parameter int BLOCK_WORDS = ICACHE_BLOCK_WORDS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ren,
  input  logic [31:0]  addr,
  output logic [31:0]  instr,
  output logic         valid,
  output logic         stall,
  input  logic         flush,
  icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int WORD_W     = $clog2(BLOCK_WORDS);
  localparam int OFF_W      = WORD_W + 2;
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = 32 - OFF_W - IDX_W;
  localparam int BLK_W      = 32 - OFF_W;
  localparam int BLOCK_BITS = 32 * BLOCK_WORDS;

  icache_state_e state_q, state_d;
  logic          pend_flush_q, pend_flush_d;
  logic [BLK_W-1:0] blk_q;

  logic [WORD_W-1:0] word_sel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [BLK_W-1:0]  blk;
  logic              unused_byte_off;

  logic [TAG_W-1:0]      line_tag;
  logic                  line_valid;
  logic [BLOCK_BITS-1:0] line_data;
  logic                  line_hit;

  logic fill_we, fill_valid, clear_all, latch_miss, mem_ren_c;

  assign word_sel        = addr[OFF_W-1:2];
  assign idx             = addr[OFF_W+IDX_W-1:OFF_W];
  assign tag             = addr[31:OFF_W+IDX_W];
  assign blk             = addr[31:OFF_W];
  assign unused_byte_off = ^addr[1:0];

  assign line_hit = line_valid && (line_tag == tag);

  icache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .BLOCK_BITS (BLOCK_BITS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clock     (clock),
    .reset     (reset),
    .clear_all (clear_all),
    .we        (fill_we),
    .widx      (blk_q[IDX_W-1:0]),
    .wtag      (blk_q[BLK_W-1:IDX_W]),
    .wdata     (mem.mem_dout),
    .wvalid    (fill_valid),
    .ridx      (idx),
    .rtag      (line_tag),
    .rvalid    (line_valid),
    .rdata     (line_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_ff @(posedge clock) begin
    if (latch_miss) begin
      blk_q <= blk;
    end
  end

  // Outputs are held at their reset values while reset is asserted, independent of ren.
  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    valid        = 1'b0;
    stall        = 1'b0;
    instr        = '0;
    mem_ren_c    = 1'b0;
    fill_we      = 1'b0;
    fill_valid   = 1'b0;
    clear_all    = 1'b0;
    latch_miss   = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            clear_all = 1'b1;
            stall     = 1'b1;
          end else if (ren) begin
            if (line_hit) begin
              valid = 1'b1;
              instr = line_data[{word_sel, 5'b0} +: 32];
            end else begin
              stall      = 1'b1;
              latch_miss = 1'b1;
              state_d    = REFILL;
            end
          end
        end
        REFILL: begin
          mem_ren_c = 1'b1;
          stall     = 1'b1;
          if (flush) begin
            pend_flush_d = 1'b1;
          end
          if (mem.mem_ready) begin
            fill_we    = 1'b1;
            fill_valid = !(pend_flush_q || flush);
            state_d    = FILL_DONE;
          end
        end
        FILL_DONE: begin
          stall        = 1'b1;
          clear_all    = pend_flush_q || flush;
          pend_flush_d = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem.mem_ren           = mem_ren_c;
  assign mem.mem_block_address = blk_q;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (valid && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (latch_miss && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
